// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared types and constants for the pixel-pipeline run controller.
//   ctrl_state_t   : run FSM state (IDLE/RUN/STOP_PEND), also readable in STATUS[1:0]
//   ADDR_*         : register word addresses
//   CTRL_*         : bit indices inside the CTRL register
//   KERNEL_ID      : identity 3x3 kernel (centre byte = 1), reset value of the kernel
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } ctrl_state_t;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_MODE      = 3'd1;
  localparam logic [2:0] ADDR_KERN0     = 3'd2;
  localparam logic [2:0] ADDR_KERN1     = 3'd3;
  localparam logic [2:0] ADDR_KERN2     = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd6;
  localparam logic [2:0] ADDR_PIX_CNT   = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_CONT    = 2;
  localparam int CTRL_IRQ_CLR = 3;

  localparam logic [71:0] KERNEL_ID = 72'h00_0000_0001_0000_0000;

endpackage

// File: rtl/proc_ctrl_regs.sv
// proc_ctrl_regs: register file of the run controller.
//   Holds the shadow mode/kernel copies and the CONT latch, decodes write
//   strobes for the top, and provides the registered read path.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   reg_we_i/reg_re_i       : write / read strobes
//   reg_addr_i, reg_wdata_i : word address, write data
//   state_i, cfg_pending_i, irq_i, frame_cnt_i, pix_cnt_i : status sources
//   shadow_mode_o, shadow_kernel_o : shadow configuration
//   cont_o                  : latched continuous-mode bit
//   ctrl_wr_o, cfg_wr_o     : this cycle writes CTRL / any of MODE,KERN0..2
//   reg_rdata_o, reg_rvalid_o : read data, valid one cycle after reg_re_i
module proc_ctrl_regs
  import proc_ctrl_pkg::*;
#(
  parameter int PIX_W  = 10,
  parameter int FCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_we_i,
  input  logic              reg_re_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  input  ctrl_state_t       state_i,
  input  logic              cfg_pending_i,
  input  logic              irq_i,
  input  logic [FCNT_W-1:0] frame_cnt_i,
  input  logic [PIX_W-1:0]  pix_cnt_i,
  output logic [1:0]        shadow_mode_o,
  output logic [71:0]       shadow_kernel_o,
  output logic              cont_o,
  output logic              ctrl_wr_o,
  output logic              cfg_wr_o,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_rvalid_o
);

  logic [1:0]  mode_q, mode_d;
  logic [71:0] kern_q, kern_d;
  logic        cont_q, cont_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [31:0] rd_mux;

  assign ctrl_wr_o = reg_we_i && (reg_addr_i == ADDR_CTRL);
  assign cfg_wr_o  = reg_we_i && (reg_addr_i >= ADDR_MODE) && (reg_addr_i <= ADDR_KERN2);

  always_comb begin
    mode_d = mode_q;
    kern_d = kern_q;
    cont_d = cont_q;
    if (reg_we_i) begin
      case (reg_addr_i)
        ADDR_CTRL:  cont_d = reg_wdata_i[CTRL_CONT];
        ADDR_MODE:  mode_d = reg_wdata_i[1:0];
        ADDR_KERN0: kern_d[31:0]  = reg_wdata_i;
        ADDR_KERN1: kern_d[63:32] = reg_wdata_i;
        ADDR_KERN2: kern_d[71:64] = reg_wdata_i[7:0];
        default: ;
      endcase
    end
  end

  // CTRL is write-only and reads back as 0.
  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      ADDR_MODE:      rd_mux = {30'd0, mode_q};
      ADDR_KERN0:     rd_mux = kern_q[31:0];
      ADDR_KERN1:     rd_mux = kern_q[63:32];
      ADDR_KERN2:     rd_mux = {24'd0, kern_q[71:64]};
      ADDR_STATUS:    rd_mux = {28'd0, irq_i, cfg_pending_i, state_i};
      ADDR_FRAME_CNT: rd_mux = 32'(frame_cnt_i);
      ADDR_PIX_CNT:   rd_mux = 32'(pix_cnt_i);
      default:        rd_mux = '0;
    endcase
  end

  assign rdata_d = reg_re_i ? rd_mux : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= 2'd0;
      kern_q   <= KERNEL_ID;
      cont_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      kern_q   <= kern_d;
      cont_q   <= cont_d;
      rdata_q  <= rdata_d;
      rvalid_q <= reg_re_i;
    end
  end

  assign shadow_mode_o   = mode_q;
  assign shadow_kernel_o = kern_q;
  assign cont_o          = cont_q;
  assign reg_rdata_o     = rdata_q;
  assign reg_rvalid_o    = rvalid_q;

endmodule

// File: rtl/proc_ctrl.sv
// proc_ctrl: register-mapped run controller for the pixel pipeline.
//   Gates the data_proc -> sink handshake so processing starts/stops on frame
//   boundaries, holds the active mode/kernel (loaded from shadow only at START
//   or at a frame boundary), counts pixels and frames, raises frame-done irq.
// Handshake: a pixel transfers on a cycle where pix_valid && pix_ready; both
//   pix_ready and sink_valid are combinational and forced low in IDLE.
// Ports: clk, rst (sync, active-high); reg_we/reg_re/reg_addr/reg_wdata/
//   reg_rdata/reg_rvalid register bus; mode/kernel active config;
//   pix_valid/pix_ready upstream; sink_valid/sink_ready downstream; irq.
// Build option: define PROC_CTRL_IRQ_EN to implement irq; otherwise irq is 0.
module proc_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int IMAGE_SIZE = 1024,
  parameter int FCNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic [1:0]  mode,
  output logic [71:0] kernel,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        sink_valid,
  input  logic        sink_ready,
  output logic        irq
);

  localparam int PIX_W = $clog2(IMAGE_SIZE);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);

  ctrl_state_t       state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [71:0]       kernel_q, kernel_d;
  logic              cfg_pending_q, cfg_pending_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [1:0]  shadow_mode;
  logic [71:0] shadow_kernel;
  logic        cont, ctrl_wr, cfg_wr;
  logic        running, xfer, eof, start, stop, load_active;

  proc_ctrl_regs #(.PIX_W(PIX_W), .FCNT_W(FCNT_W)) u_regs (
    .clk_i           (clk),
    .rst_i           (rst),
    .reg_we_i        (reg_we),
    .reg_re_i        (reg_re),
    .reg_addr_i      (reg_addr),
    .reg_wdata_i     (reg_wdata),
    .state_i         (state_q),
    .cfg_pending_i   (cfg_pending_q),
    .irq_i           (irq),
    .frame_cnt_i     (frame_cnt_q),
    .pix_cnt_i       (pix_cnt_q),
    .shadow_mode_o   (shadow_mode),
    .shadow_kernel_o (shadow_kernel),
    .cont_o          (cont),
    .ctrl_wr_o       (ctrl_wr),
    .cfg_wr_o        (cfg_wr),
    .reg_rdata_o     (reg_rdata),
    .reg_rvalid_o    (reg_rvalid)
  );

  assign running    = (state_q != IDLE);
  assign pix_ready  = sink_ready && running;
  assign sink_valid = pix_valid && running;
  assign xfer       = pix_valid && pix_ready;
  assign eof        = xfer && (pix_cnt_q == PIX_LAST);
  assign start      = ctrl_wr && reg_wdata[CTRL_START];
  assign stop       = ctrl_wr && reg_wdata[CTRL_STOP];

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    kernel_d      = kernel_q;
    cfg_pending_d = cfg_pending_q;
    pix_cnt_d     = pix_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    load_active   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = RUN;
          load_active = 1'b1;
        end
      end
      // A STOP landing on the last pixel ends the run at this boundary
      // rather than committing to one more frame.
      RUN: begin
        if (eof && (!cont || stop)) state_d = IDLE;
        else if (stop)              state_d = STOP_PEND;
      end
      STOP_PEND: begin
        if (eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      if (eof) begin
        pix_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (cfg_pending_q) load_active = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end

    // Loads copy the pre-write shadow; a shadow write in the same cycle
    // keeps cfg_pending set so it lands at the next boundary.
    if (load_active) begin
      mode_d        = shadow_mode;
      kernel_d      = shadow_kernel;
      cfg_pending_d = 1'b0;
    end
    if (cfg_wr) cfg_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= 2'd0;
      kernel_q      <= KERNEL_ID;
      cfg_pending_q <= 1'b0;
      pix_cnt_q     <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      kernel_q      <= kernel_d;
      cfg_pending_q <= cfg_pending_d;
      pix_cnt_q     <= pix_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign mode   = mode_q;
  assign kernel = kernel_q;

`ifdef PROC_CTRL_IRQ_EN
  logic irq_q, irq_d;

  // Set on end of frame wins over a simultaneous IRQ_CLR.
  always_comb begin
    irq_d = irq_q;
    if (ctrl_wr && reg_wdata[CTRL_IRQ_CLR]) irq_d = 1'b0;
    if (eof) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_proc_ctrl.sv
module tb_proc_ctrl;

  localparam int IMAGE_SIZE = 1024;
  localparam int FCNT_W     = 16;
  localparam logic [71:0] KID = 72'h00_0000_0001_0000_0000;
`ifdef PROC_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        reg_we, reg_re;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_rvalid;
  logic [1:0]  mode;
  logic [71:0] kernel;
  logic        pix_valid, pix_ready, sink_valid, sink_ready, irq;

  proc_ctrl #(.IMAGE_SIZE(IMAGE_SIZE), .FCNT_W(FCNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .mode       (mode),
    .kernel     (kernel),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: run status 0=idle 1=running 2=stopping, counts as integers.
  int          m_state;
  bit          m_cont, m_pend, m_irq, m_rv;
  int unsigned m_pix, m_frame;
  logic [1:0]  sh_mode, act_mode;
  logic [71:0] sh_kern, act_kern;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd1: return {30'd0, sh_mode};
      3'd2: return sh_kern[31:0];
      3'd3: return sh_kern[63:32];
      3'd4: return {24'd0, sh_kern[71:64]};
      3'd5: return {28'd0, IRQ_EN && m_irq, m_pend, 2'(m_state)};
      3'd6: return 32'(m_frame);
      3'd7: return 32'(m_pix);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit xfer, eof, cwr, start, stop, load, cfg;
    if (rst) begin
      m_state = 0; m_cont = 0; m_pend = 0; m_irq = 0; m_rv = 0;
      m_pix = 0; m_frame = 0;
      sh_mode = 0; act_mode = 0; sh_kern = KID; act_kern = KID;
      exp_q.delete();
    end else begin
      m_rv = reg_re;
      if (reg_re) exp_q.push_back(model_read(reg_addr));
      xfer  = pix_valid && sink_ready && (m_state != 0);
      eof   = xfer && (m_pix == IMAGE_SIZE - 1);
      cwr   = reg_we && (reg_addr == 3'd0);
      start = cwr && reg_wdata[0];
      stop  = cwr && reg_wdata[1];
      cfg   = reg_we && (reg_addr >= 3'd1) && (reg_addr <= 3'd4);
      load  = 0;
      if (m_state == 0) begin
        if (start && !stop) begin m_state = 1; load = 1; end
      end else if (m_state == 1) begin
        if (eof && (!m_cont || stop)) m_state = 0;
        else if (stop) m_state = 2;
      end else begin
        if (eof) m_state = 0;
      end
      if (eof) begin
        m_pix = 0;
        m_frame = (m_frame + 1) % (1 << FCNT_W);
        if (m_pend) load = 1;
      end else if (xfer) m_pix++;
      if (load) begin act_mode = sh_mode; act_kern = sh_kern; m_pend = 0; end
      if (cwr && reg_wdata[3]) m_irq = 0;
      if (eof) m_irq = 1;
      if (reg_we) begin
        case (reg_addr)
          3'd1: sh_mode = reg_wdata[1:0];
          3'd2: sh_kern[31:0] = reg_wdata;
          3'd3: sh_kern[63:32] = reg_wdata;
          3'd4: sh_kern[71:64] = reg_wdata[7:0];
          default: ;
        endcase
      end
      if (cfg) m_pend = 1;
      if (cwr) m_cont = reg_wdata[2];
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (pix_valid && pix_ready) n_xfer++;
      check("pix_ready", pix_ready, sink_ready && (m_state != 0));
      check("sink_valid", sink_valid, pix_valid && (m_state != 0));
      check("mode", mode, act_mode);
      check("kernel", kernel, act_kern);
      check("irq", irq, IRQ_EN && m_irq);
      check("rvalid", reg_rvalid, m_rv);
      if (m_rv && exp_q.size() > 0) check("rdata", reg_rdata, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_re = 1'b1; reg_addr = a;
    tick();
    reg_re = 1'b0;
    d = reg_rdata;
  endtask

  task automatic wait_pix(input int unsigned target, input int bound, input string name);
    int i = 0;
    while (m_pix != target && i < bound) begin tick(); i++; end
    if (m_pix != target) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for pixel %0d, at %0d", name, target, m_pix);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i = 0;
    while (m_state != 0 && i < bound) begin tick(); i++; end
    if (m_state != 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for idle, state %0d", name, m_state);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    rst = 1'b1; reg_we = 0; reg_re = 0; reg_addr = 0; reg_wdata = 0;
    pix_valid = 0; sink_ready = 0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    check("rst_kernel", kernel, KID);
    check("rst_mode", mode, 2'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_rvalid", reg_rvalid, 1'b0);
    check("rst_rdata", reg_rdata, 32'd0);
    rd(3'd5, d); check("rst_status", d, 32'd0);
    rd(3'd3, d); check("rst_kern1", d, 32'h1);

    // START|STOP together in IDLE stays idle
    pix_valid = 1; sink_ready = 1;
    wr(3'd0, 32'h3);
    check("startstop_ready", pix_ready, 1'b0);
    rd(3'd5, d); check("startstop_status", d, 32'd0);

    // Single frame
    wr(3'd1, 32'd2);
    n_xfer = 0;
    wr(3'd0, 32'h1);
    check("frame1_mode", mode, 2'd2);
    check("frame1_ready", pix_ready, 1'b1);
    wait_idle(1100, "frame1");
    check("frame1_xfers", n_xfer, 1024);
    check("frame1_ready_after", pix_ready, 1'b0);
    check("frame1_irq", irq, IRQ_EN);
    rd(3'd6, d); check("frame1_fcnt", d, 32'd1);
    rd(3'd5, d); check("frame1_status", d, IRQ_EN ? 32'h8 : 32'h0);
    wr(3'd0, 32'h8);
    check("irq_clr", irq, 1'b0);

    // Deferred config, IRQ_CLR on end of frame
    wr(3'd0, 32'h5);
    wait_pix(500, 1100, "defer_500");
    wr(3'd2, 32'hDEADBEEF);
    check("defer_hold", kernel[31:0], 32'h0);
    rd(3'd5, d); check("defer_pend", d & 32'h4, 32'h4);
    wait_pix(1023, 1100, "defer_eof");
    wr(3'd0, 32'hC);
    check("defer_apply", kernel[31:0], 32'hDEADBEEF);
    check("irqclr_eof", irq, IRQ_EN);
    rd(3'd5, d); check("defer_pend_clr", d & 32'h4, 32'h0);

    // MODE write on end-of-frame cycle
    wait_pix(1023, 1100, "mode_eof");
    wr(3'd1, 32'd3);
    check("mode_eof_hold", mode, 2'd2);
    rd(3'd5, d); check("mode_eof_pend", d & 32'h4, 32'h4);

    // Stop mid-frame
    wait_pix(10, 1100, "stop_10");
    wr(3'd0, 32'h6);
    rd(3'd5, d); check("stop_state", d & 32'h3, 32'h2);
    wait_idle(1100, "stop");
    check("stop_ready", pix_ready, 1'b0);
    tick(); tick(); tick();
    check("stop_ready_later", pix_ready, 1'b0);
    check("stop_mode", mode, 2'd3);
    rd(3'd6, d); check("stop_fcnt", d, 32'd4);

    // Backpressure: sink_ready toggles every cycle
    wr(3'd0, 32'h9);
    begin
      int i = 0;
      while (m_state != 0 && i < 3000) begin
        sink_ready = ~sink_ready;
        tick(); i++;
      end
      if (m_state != 0) begin
        n_checks++; n_errors++;
        $display("FAIL backpressure: timeout, state %0d", m_state);
      end
    end
    rd(3'd6, d); check("bp_fcnt", d, 32'd5);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      int op;
      pix_valid  = ($urandom_range(0, 3) != 0);
      sink_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 63);
      if (op == 0 && m_pix != IMAGE_SIZE - 1) begin
        reg_we = 1; reg_addr = 3'd0; reg_wdata = $urandom_range(0, 15);
      end else if (op >= 1 && op <= 3) begin
        reg_we = 1; reg_addr = 3'($urandom_range(1, 4)); reg_wdata = $urandom;
      end else if (op >= 4 && op <= 9) begin
        reg_re = 1; reg_addr = 3'($urandom_range(0, 7));
      end else if (op >= 60 && m_state == 0) begin
        reg_we = 1; reg_addr = 3'd0; reg_wdata = {29'd0, 1'($urandom_range(0, 1)), 2'b01};
      end
      tick();
      reg_we = 0; reg_re = 0;
    end

    // Reset mid-frame
    pix_valid = 1; sink_ready = 1;
    wr(3'd0, 32'h2);
    wait_idle(3000, "pre_reset");
    wr(3'd0, 32'h1);
    wait_pix(300, 1100, "reset_300");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_ready", pix_ready, 1'b0);
    check("mrst_kernel", kernel, KID);
    check("mrst_mode", mode, 2'd0);
    check("mrst_irq", irq, 1'b0);
    rd(3'd7, d); check("mrst_pcnt", d, 32'd0);
    rd(3'd6, d); check("mrst_fcnt", d, 32'd0);
    rd(3'd5, d); check("mrst_status", d, 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
